// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache with one-cycle hits.
// Define ARB_FAIR_EN to bound data streaks while an instr request waits.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_DSTRK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        RESP
    } state_t;

    state_t state;
    logic   fair;
    logic   gnt_d;
    logic   gnt_i;

    if (MAX_DSTRK < 1) begin : g_bad_cfg
        $error("MAX_DSTRK must be at least 1");
    end

`ifdef ARB_FAIR_EN
    localparam int SW = $clog2(MAX_DSTRK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DSTRK);

    logic [SW-1:0] streak;

    assign fair = iREN && (streak == SMAX);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (gnt_i) begin
                streak <= '0;
            end else if (gnt_d && iREN && streak != SMAX) begin
                streak <= streak + 1'b1;
            end
        end
    end
`else
    assign fair = 1'b0;
`endif

    // A saturated streak hands the next slot to the waiting instr fetch.
    always_comb begin
        gnt_d = (dREN || dWEN) && !fair;
        gnt_i = iREN && !gnt_d;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_d) begin
                        state    <= DACC;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        ramWEN   <= dWEN;
                        ramREN   <= !dWEN;
                    end else if (gnt_i) begin
                        state   <= IACC;
                        ramaddr <= iaddr;
                        ramWEN  <= 1'b0;
                        ramREN  <= 1'b1;
                    end
                end
                IACC, DACC: begin
                    if (ram_ready) begin
                        state  <= RESP;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (state == IACC) begin
                            ihit  <= 1'b1;
                            iload <= ramload;
                        end else begin
                            dhit <= 1'b1;
                            if (ramREN) begin
                                dload <= ramload;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model
// plus directed latency, wait-state, reset and fairness scenarios.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          ihit;
    logic [DW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dhit;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic          ram_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_DSTRK(MAXS)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight at a time.
    // busy = RAM access outstanding, done = hit cycle.
    bit            busy;
    bit            done;
    bit            rst_now;
    bit            m_isd;
    bit            m_wr;
    bit            want_d;
    bit            take_i;
    int            streak;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_store;
    logic [DW-1:0] m_iload;
    logic [DW-1:0] m_dload;

    always @(posedge CLK) begin
        #1;
        if (!nRST) begin
            busy    = 0;
            done    = 0;
            rst_now = 1;
            m_isd   = 0;
            m_wr    = 0;
            streak  = 0;
            m_addr  = '0;
            m_store = '0;
            m_iload = '0;
            m_dload = '0;
        end else begin
            rst_now = 0;
            if (done) begin
                done = 0;
            end else if (busy) begin
                if (ram_ready) begin
                    if (!m_wr && m_isd) m_dload = ramload;
                    if (!m_wr && !m_isd) m_iload = ramload;
                    busy = 0;
                    done = 1;
                end
            end else begin
                want_d = dREN || dWEN;
`ifdef ARB_FAIR_EN
                take_i = iREN && (!want_d || streak >= MAXS);
`else
                take_i = iREN && !want_d;
`endif
                if (take_i) begin
                    busy   = 1;
                    m_isd  = 0;
                    m_wr   = 0;
                    m_addr = iaddr;
                    streak = 0;
                end else if (want_d) begin
                    busy    = 1;
                    m_isd   = 1;
                    m_wr    = dWEN;
                    m_addr  = daddr;
                    m_store = dstore;
                    if (iREN && streak < MAXS) streak++;
                end
            end
        end
        chk("m_ramREN", ramREN, busy && !m_wr);
        chk("m_ramWEN", ramWEN, busy && m_wr);
        chk("m_ihit", ihit, done && !m_isd);
        chk("m_dhit", dhit, done && m_isd);
        chk("m_iload", iload, m_iload);
        chk("m_dload", dload, m_dload);
        if (busy || rst_now) chk("m_ramaddr", ramaddr, m_addr);
        if ((busy && m_wr) || rst_now)
            chk("m_ramstore", ramstore, m_store);
    end

    task automatic step();
        @(negedge CLK);
    endtask

    logic [DW-1:0] old_dload;
    int            nh;
    int            icnt;
    int            dcnt;
    bit            seq[$];

    initial begin
        nRST      = 1'b0;
        iREN      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        iaddr     = '0;
        daddr     = '0;
        dstore    = '0;
        ramload   = '0;
        ram_ready = 1'b0;
        repeat (3) step();
        chk("rst_ihit", ihit, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_iload", iload, 0);
        nRST = 1'b1;
        step();

        // Solo instruction read
        iREN      = 1'b1;
        iaddr     = 32'h40;
        ram_ready = 1'b1;
        ramload   = 32'hDEADBEEF;
        step();
        chk("solo_ramREN", ramREN, 1);
        chk("solo_ramaddr", ramaddr, 32'h40);
        step();
        chk("solo_ihit", ihit, 1);
        chk("solo_iload", iload, 32'hDEADBEEF);
        iREN = 1'b0;
        step();
        chk("solo_ihit_once", ihit, 0);

        // Contention: data first, then instr
        iREN    = 1'b1;
        iaddr   = 32'h44;
        dREN    = 1'b1;
        daddr   = 32'h100;
        ramload = 32'hA5A5A5A5;
        step();
        chk("cont_daddr", ramaddr, 32'h100);
        step();
        chk("cont_dhit", dhit, 1);
        chk("cont_no_ihit", ihit, 0);
        chk("cont_dload", dload, 32'hA5A5A5A5);
        dREN = 1'b0;
        step();
        chk("cont_idle", ramREN, 0);
        step();
        chk("cont_iaddr", ramaddr, 32'h44);
        step();
        chk("cont_ihit", ihit, 1);
        iREN = 1'b0;
        step();

        // Write with three wait states
        dWEN      = 1'b1;
        daddr     = 32'h80;
        dstore    = 32'h1234;
        ram_ready = 1'b0;
        old_dload = dload;
        chk("ws_old_dload", old_dload, 32'hA5A5A5A5);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("ws_ramWEN", ramWEN, 1);
            chk("ws_ramREN", ramREN, 0);
            chk("ws_ramaddr", ramaddr, 32'h80);
            chk("ws_ramstore", ramstore, 32'h1234);
            chk("ws_no_dhit", dhit, 0);
            if (k == 4) ram_ready = 1'b1;
        end
        step();
        chk("ws_dhit", dhit, 1);
        chk("ws_dload_kept", dload, 32'hA5A5A5A5);
        dWEN = 1'b0;
        step();

        // Read+write together acts as a single write
        dREN   = 1'b1;
        dWEN   = 1'b1;
        daddr  = 32'hC0;
        dstore = 32'h55;
        step();
        chk("dual_ramWEN", ramWEN, 1);
        chk("dual_ramREN", ramREN, 0);
        step();
        chk("dual_dhit", dhit, 1);
        step();
        chk("dual_no_reissue", ramWEN, 0);
        chk("dual_hit_once", dhit, 0);
        dREN = 1'b0;
        dWEN = 1'b0;
        step();

        // Reset in the middle of a write
        dWEN      = 1'b1;
        daddr     = 32'h200;
        dstore    = 32'h77;
        ram_ready = 1'b0;
        step();
        chk("rmid_ramWEN", ramWEN, 1);
        nRST = 1'b0;
        dWEN = 1'b0;
        step();
        chk("rmid_ramWEN0", ramWEN, 0);
        chk("rmid_ramREN0", ramREN, 0);
        chk("rmid_ramaddr", ramaddr, 0);
        chk("rmid_ramstore", ramstore, 0);
        chk("rmid_dhit", dhit, 0);
        chk("rmid_dload", dload, 0);
        nRST = 1'b1;
        step();
        chk("rmid_after", dhit, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            if (ihit || !iREN) begin
                iREN  = ($urandom_range(2) == 0);
                iaddr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(60) == 0) begin
                iREN = 1'b0;
            end
            if (dhit || !(dREN || dWEN)) begin
                dREN   = ($urandom_range(2) != 0);
                dWEN   = ($urandom_range(2) == 0);
                daddr  = $urandom & 32'hFFFF_FFFC;
                dstore = $urandom;
            end else if ($urandom_range(60) == 0) begin
                dREN = 1'b0;
                dWEN = 1'b0;
            end
            ram_ready = ($urandom_range(2) != 0);
            ramload   = $urandom;
            nRST      = ($urandom_range(250) != 0);
        end

        // Continuous contention
        nRST = 1'b0;
        step();
        nRST      = 1'b1;
        iREN      = 1'b1;
        dREN      = 1'b1;
        dWEN      = 1'b0;
        ram_ready = 1'b1;
        icnt      = 0;
        dcnt      = 0;
        for (int c = 0; c < 45; c++) begin
            step();
            ramload = $urandom;
            if (dhit) begin
                seq.push_back(1'b1);
                dcnt++;
            end
            if (ihit) begin
                seq.push_back(1'b0);
                icnt++;
            end
        end
`ifdef ARB_FAIR_EN
        nh = seq.size();
        chk("fair_nhits", nh >= 10, 1);
        for (int k = 0; k < 10 && k < nh; k++)
            chk("fair_order", seq[k], (k % 5) != 4);
`else
        chk("starve_ihits", icnt, 0);
        chk("starve_dhits", dcnt >= 10, 1);
`endif
        iREN = 1'b0;
        dREN = 1'b0;
        step();
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
